clarvi_byte_sequencer: RTL and testbench

- Front end for the byte-serial ALU, which processes one 8-bit slice per cycle and carries inter-slice state internally.
- Accepts one complete 64-bit operation over a valid/ready request port.
- Issues the eight byte-parts to the ALU in the order each operation requires, and collects the returned result bytes.
- Reassembles the bytes into a 64-bit result and presents it on a valid/ready response port to the execute stage.

---
 rtl/clarvi_byte_sequencer.sv | 164 ++++++++++++++++
 tb/tb_clarvi_byte_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/clarvi_byte_sequencer.sv
// Byte-serial ALU front end: accepts one 64-bit operation, issues its eight
// byte-parts to the ALU in the order the op needs, collects the result bytes
// and returns the reassembled 64-bit result over a valid/ready port.
module clarvi_byte_sequencer #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned OP_W   = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [OP_W-1:0]   req_op,
    input  logic              req_is32,
    input  logic              req_imm_used,
    input  logic [DATA_W-1:0] req_rs1,
    input  logic [DATA_W-1:0] req_rs2,
    input  logic [DATA_W-1:0] req_imm,
    input  logic [DATA_W-1:0] req_pc,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_result,
    output logic [OP_W-1:0]   alu_op,
    output logic [2:0]        alu_part,
    output logic              alu_is32,
    output logic              alu_imm_used,
    output logic [7:0]        alu_rs1,
    output logic [7:0]        alu_rs2,
    output logic [7:0]        alu_imm,
    output logic [DATA_W-1:0] alu_pc,
    output logic              alu_stall,
    input  logic [7:0]        alu_result
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [OP_W-1:0] {
        OP_ADD,
        OP_SUB,
        OP_SL,
        OP_SLT,
        OP_SLTU,
        OP_XOR,
        OP_SRL,
        OP_SRA,
        OP_OR,
        OP_AND,
        OP_AUIPC,
        OP_JAL,
        OP_JALR
    } op_t;

    state_t            r_state;
    logic [2:0]        r_step;
    logic [OP_W-1:0]   r_op;
    logic              r_is32;
    logic              r_imm_used;
    logic [DATA_W-1:0] r_rs1;
    logic [DATA_W-1:0] r_rs2;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_result;
    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_stall;

    logic              w_is_shift;
    logic              w_is_right;
    logic              w_desc;
    logic              w_split;
    logic [2:0]        w_part;
    logic [5:0]        w_idx;

    // Map the step counter onto the byte part required by the latched op.
    always_comb begin
        w_is_shift = (r_op == OP_SL) || (r_op == OP_SRL) || (r_op == OP_SRA);
        w_is_right = (r_op == OP_SRL) || (r_op == OP_SRA);
        w_desc     = (r_op == OP_SLT) || (r_op == OP_SLTU) || (w_is_right && !r_is32);
        w_split    = w_is_right && r_is32;
        w_part     = r_step;
        if (w_desc) begin
            w_part = ~r_step;
        end else if (w_split) begin
            // 3,2,1,0 then 7,6,5,4: low word top-down, then its sign extension
            w_part = {r_step[2], ~r_step[1:0]};
        end
        w_idx = {w_part, 3'b000};
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_result  = r_result;
    assign alu_op       = r_op;
    assign alu_part     = w_part;
    assign alu_is32     = r_is32;
    assign alu_imm_used = r_imm_used;
    assign alu_rs1      = r_rs1[w_idx +: 8];
    assign alu_rs2      = w_is_shift ? r_rs2[7:0] : r_rs2[w_idx +: 8];
    assign alu_imm      = w_is_shift ? r_imm[7:0] : r_imm[w_idx +: 8];
    assign alu_pc       = r_pc;
    assign alu_stall    = r_stall;

    // Sequencer FSM: accept, issue eight parts, hold result until taken.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_step       <= '0;
            r_op         <= '0;
            r_is32       <= 1'b0;
            r_imm_used   <= 1'b0;
            r_rs1        <= '0;
            r_rs2        <= '0;
            r_imm        <= '0;
            r_pc         <= '0;
            r_result     <= '0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_stall      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_req_ready <= 1'b1;
                    if (req_valid && r_req_ready) begin
                        r_op        <= req_op;
                        r_is32      <= req_is32;
                        r_imm_used  <= req_imm_used;
                        r_rs1       <= req_rs1;
                        r_rs2       <= req_rs2;
                        r_imm       <= req_imm;
                        r_pc        <= req_pc;
                        r_result    <= '0;
                        r_step      <= '0;
                        r_req_ready <= 1'b0;
                        r_stall     <= 1'b0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result[w_idx +: 8] <= alu_result;
                    r_step               <= r_step + 3'd1;
                    if (r_step == 3'd7) begin
                        r_stall      <= 1'b1;
                        r_resp_valid <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clarvi_byte_sequencer.sv
// Directed bench for clarvi_byte_sequencer with a behavioural byte-serial ALU.
module tb_clarvi_byte_sequencer;

    localparam logic [4:0] OP_ADD  = 5'd0;
    localparam logic [4:0] OP_SUB  = 5'd1;
    localparam logic [4:0] OP_SL   = 5'd2;
    localparam logic [4:0] OP_SLT  = 5'd3;
    localparam logic [4:0] OP_SLTU = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SRL  = 5'd6;
    localparam logic [4:0] OP_SRA  = 5'd7;
    localparam logic [4:0] OP_UNDEF = 5'd31;

    localparam int unsigned ASC   = 0;
    localparam int unsigned DESC  = 1;
    localparam int unsigned SPLIT = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_op;
    logic        req_is32;
    logic        req_imm_used;
    logic [63:0] req_rs1;
    logic [63:0] req_rs2;
    logic [63:0] req_imm;
    logic [63:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_result;
    logic [4:0]  alu_op;
    logic [2:0]  alu_part;
    logic        alu_is32;
    logic        alu_imm_used;
    logic [7:0]  alu_rs1;
    logic [7:0]  alu_rs2;
    logic [7:0]  alu_imm;
    logic [63:0] alu_pc;
    logic        alu_stall;
    logic [7:0]  alu_result;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    clarvi_byte_sequencer #(.DATA_W(64), .OP_W(5)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_is32(req_is32), .req_imm_used(req_imm_used),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_pc(req_pc),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .alu_op(alu_op), .alu_part(alu_part), .alu_is32(alu_is32),
        .alu_imm_used(alu_imm_used), .alu_rs1(alu_rs1), .alu_rs2(alu_rs2),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_stall(alu_stall),
        .alu_result(alu_result)
    );

    always #5 clock = ~clock;

    // Byte-serial ALU model: remembers bytes seen so far, so a part issued
    // before the bytes it depends on yields a wrong result byte.
    logic [63:0] m_rs1, m_rs2, m_imm;
    logic [63:0] m_a, m_b, m_r;
    logic [31:0] m_w;
    logic [7:0]  m_cur;
    logic [5:0]  m_sh;
    logic [5:0]  m_idx;

    always @(posedge clock) begin
        if (!alu_stall) begin
            m_rs1[{alu_part, 3'b000} +: 8] <= alu_rs1;
            m_rs2[{alu_part, 3'b000} +: 8] <= alu_rs2;
            m_imm[{alu_part, 3'b000} +: 8] <= alu_imm;
        end
    end

    always_comb begin
        m_idx = {alu_part, 3'b000};
        m_a   = m_rs1;
        m_a[m_idx +: 8] = alu_rs1;
        m_cur = alu_imm_used ? alu_imm : alu_rs2;
        m_b   = alu_imm_used ? m_imm : m_rs2;
        m_b[m_idx +: 8] = m_cur;
        m_sh  = m_cur[5:0];
        m_w   = '0;
        m_r   = '0;
        case (alu_op)
            OP_ADD:  m_r = m_a + m_b;
            OP_SUB:  m_r = m_a - m_b;
            OP_SL:   m_r = m_a << m_sh;
            OP_SLT:  m_r = {63'd0, $signed(m_a) < $signed(m_b)};
            OP_SLTU: m_r = {63'd0, m_a < m_b};
            OP_XOR:  m_r = m_a ^ m_b;
            OP_SRL:  m_r = m_a >> m_sh;
            OP_SRA:  m_r = $signed(m_a) >>> m_sh;
            default: m_r = '0;
        endcase
        if (alu_is32) begin
            case (alu_op)
                OP_ADD: m_w = m_r[31:0];
                OP_SUB: m_w = m_r[31:0];
                OP_SL:  m_w = m_a[31:0] << m_sh[4:0];
                OP_SRL: m_w = m_a[31:0] >> m_sh[4:0];
                OP_SRA: m_w = $signed(m_a[31:0]) >>> m_sh[4:0];
                default: m_w = m_r[31:0];
            endcase
            if (alu_op == OP_ADD || alu_op == OP_SUB || alu_op == OP_SL ||
                alu_op == OP_SRL || alu_op == OP_SRA) begin
                m_r = {{32{m_w[31]}}, m_w};
            end
        end
        alu_result = m_r[m_idx +: 8];
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] exp_part(input int unsigned mode, input int unsigned i);
        logic [2:0] s;
        s = 3'(i);
        case (mode)
            DESC:    return 3'd7 - s;
            SPLIT:   return (i < 4) ? (3'd3 - s) : (3'd7 - (s - 3'd4));
            default: return s;
        endcase
    endfunction

    task automatic send(input logic [4:0] op, input logic is32, input logic immu,
                        input logic [63:0] rs1, input logic [63:0] rs2,
                        input logic [63:0] imm, input logic [63:0] pc);
        int unsigned t;
        t = 0;
        @(negedge clock);
        while (req_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        check_eq("req_ready_wait", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_op = op; req_is32 = is32; req_imm_used = immu;
        req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_pc = pc;
        @(posedge clock);
        #1;
        // Scrambled fields must not leak into the latched operation.
        req_valid = 1'b0; req_op = ~op; req_is32 = ~is32; req_imm_used = ~immu;
        req_rs1 = ~rs1; req_rs2 = ~rs2; req_imm = ~imm; req_pc = ~pc;
    endtask

    task automatic run_op(input string name, input logic [4:0] op, input logic is32,
                          input logic immu, input logic [63:0] rs1, input logic [63:0] rs2,
                          input logic [63:0] imm, input int unsigned mode,
                          input logic shift, input logic [63:0] exp, input int unsigned hold);
        logic [23:0] got_ord, exp_ord;
        logic [2:0]  p;
        int unsigned errs;
        logic [63:0] pc;
        pc = 64'h0000_0000_8000_1000 ^ {59'd0, op};
        send(op, is32, immu, rs1, rs2, imm, pc);
        got_ord = '0; exp_ord = '0; errs = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            p = exp_part(mode, i);
            got_ord[i*3 +: 3] = alu_part;
            exp_ord[i*3 +: 3] = p;
            if (alu_stall !== 1'b0 || req_ready !== 1'b0 || resp_valid !== 1'b0) errs++;
            if (alu_op !== op || alu_is32 !== is32 || alu_imm_used !== immu || alu_pc !== pc) errs++;
            if (alu_rs1 !== rs1[{p, 3'b000} +: 8]) errs++;
            if (alu_rs2 !== (shift ? rs2[7:0] : rs2[{p, 3'b000} +: 8])) errs++;
            if (alu_imm !== (shift ? imm[7:0] : imm[{p, 3'b000} +: 8])) errs++;
        end
        check_eq({name, "_order"}, {40'd0, got_ord}, {40'd0, exp_ord});
        check_eq({name, "_fields"}, 64'(errs), 64'd0);
        @(negedge clock);
        check_eq({name, "_valid_at_e9"}, {63'd0, resp_valid}, 64'd1);
        check_eq({name, "_result"}, resp_result, exp);
        errs = 0;
        for (int h = 0; h < int'(hold); h++) begin
            req_valid = 1'b1;
            @(negedge clock);
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_result !== exp ||
                alu_stall !== 1'b1) errs++;
        end
        if (hold > 0) check_eq({name, "_hold"}, 64'(errs), 64'd0);
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        @(negedge clock);
        check_eq({name, "_valid_drop"}, {63'd0, resp_valid}, 64'd0);
        check_eq({name, "_ready_back"}, {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = '0; req_is32 = 1'b0; req_imm_used = 1'b0;
        req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_pc = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check_eq("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("rst_resp_result", resp_result, 64'd0);
        check_eq("rst_alu_stall", {63'd0, alu_stall}, 64'd1);
        check_eq("rst_alu_fields", {alu_rs1, alu_rs2, alu_imm, alu_op, alu_part,
                                    alu_is32, alu_imm_used, 30'd0}, 64'd0);
        check_eq("rst_alu_pc", alu_pc, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("ready_after_reset", {63'd0, req_ready}, 64'd1);

        run_op("add64", OP_ADD, 0, 0, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'd0,
               ASC, 0, 64'h0000_0001_0000_0000, 0);
        run_op("add32", OP_ADD, 1, 0, 64'h0000_0000_7FFF_FFFF, 64'd1, 64'd0,
               ASC, 0, 64'hFFFF_FFFF_8000_0000, 0);
        run_op("addi", OP_ADD, 0, 1, 64'd5, 64'h1111_2222_3333_4444, 64'hFFFF_FFFF_FFFF_FFF9,
               ASC, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("sub64", OP_SUB, 0, 0, 64'd5, 64'd7, 64'd0,
               ASC, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0);
        run_op("slt", OP_SLT, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
               DESC, 0, 64'd1, 0);
        run_op("sltu", OP_SLTU, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
               DESC, 0, 64'd0, 0);
        run_op("slt_eq", OP_SLT, 0, 0, 64'h1234, 64'h1234, 64'd0,
               DESC, 0, 64'd0, 0);
        run_op("sra64", OP_SRA, 0, 0, 64'h8000_0000_0000_0000, 64'd4, 64'h5A,
               DESC, 1, 64'hF800_0000_0000_0000, 0);
        run_op("sl64", OP_SL, 0, 0, 64'd1, 64'd63, 64'h77,
               ASC, 1, 64'h8000_0000_0000_0000, 0);
        run_op("srl32", OP_SRL, 1, 0, 64'h0000_0000_8000_0000, 64'd4, 64'd0,
               SPLIT, 1, 64'h0000_0000_0800_0000, 0);
        run_op("sra32", OP_SRA, 1, 0, 64'h0000_0000_8000_0000, 64'd4, 64'd0,
               SPLIT, 1, 64'hFFFF_FFFF_F800_0000, 0);
        run_op("xor", OP_XOR, 0, 0, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'd0,
               ASC, 0, 64'h0FF0_0FF0_0FF0_0FF0, 0);
        run_op("undef", OP_UNDEF, 0, 0, 64'h0123_4567_89AB_CDEF, 64'h1111, 64'd0,
               ASC, 0, 64'd0, 0);
        run_op("hold", OP_ADD, 0, 0, 64'd40, 64'd2, 64'd0,
               ASC, 0, 64'd42, 5);

        // Abort an operation at step 4 with reset.
        send(OP_ADD, 0, 0, 64'h10, 64'h20, 64'd0, 64'h40);
        repeat (5) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("abort_resp_valid", {63'd0, resp_valid}, 64'd0);
        check_eq("abort_req_ready", {63'd0, req_ready}, 64'd0);
        check_eq("abort_stall", {63'd0, alu_stall}, 64'd1);
        check_eq("abort_result", resp_result, 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check_eq("abort_ready_back", {63'd0, req_ready}, 64'd1);
        check_eq("abort_no_valid", {63'd0, resp_valid}, 64'd0);
        run_op("post_abort", OP_ADD, 0, 0, 64'd2, 64'd3, 64'd0,
               ASC, 0, 64'd5, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
